stg1ia_pq: RTL and testbench

- Parametrised instruction-address stage with a small in-flight PC queue.
- Owns the program counter and issues FETCH_W consecutive fetch addresses per request, under a request/grant handshake with instruction memory.
- Tracks each granted request in a DEPTH-entry queue and presents the head PC downstream with a valid/ready handshake.
- Supports flush with redirect target; sits between branch resolution and the instruction-decode stage.

---
 rtl/stg1ia_pq.sv | 136 +++++++++++++
 tb/tb_stg1ia_pq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stg1ia_pq.sv
// stg1ia_pq: instruction-address stage with program counter and in-flight PC queue.
// Issues FETCH_W consecutive fetch addresses per request (request/grant),
// records each granted PC in a DEPTH-entry circular queue and presents the
// head PC downstream with valid/ready. Flush redirects the PC and empties the queue.
// Optional build macro STG1IA_PQ_PERF_EN adds saturating stall/flush counters.
module stg1ia_pq #(
    parameter int unsigned      ADDR_W   = 24,
    parameter int unsigned      FETCH_W  = 2,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        iw_clk,
    input  logic                        iw_rst_n,
    output logic [FETCH_W*ADDR_W-1:0]   ow_mem_addr,
    output logic                        ow_mem_req,
    input  logic                        iw_mem_gnt,
    output logic [ADDR_W-1:0]           ow_pc,
    output logic                        ow_ia_valid,
    input  logic                        iw_ready,
    output logic [$clog2(DEPTH):0]      ow_count,
    input  logic                        iw_flush,
    input  logic [ADDR_W-1:0]           iw_flush_pc
`ifdef STG1IA_PQ_PERF_EN
    ,
    output logic [31:0]                 ow_perf_stall,
    output logic [31:0]                 ow_perf_flush
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_n;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_n;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] head_pc_n;
    logic              head_valid_n;
    logic              pop;
    logic              push;

    // Fetch address slices: PC + i, wrapping silently at the top of the space
    for (genvar i = 0; i < FETCH_W; i++) begin : g_addr
        assign ow_mem_addr[i*ADDR_W +: ADDR_W] = pc_q + ADDR_W'(i);
    end

    assign ow_count = count_q;
    assign pop      = ow_ia_valid && iw_ready && !iw_flush;
    // A full queue can still request when the head is consumed in the same cycle
    assign ow_mem_req = iw_rst_n && !iw_flush &&
                        ((count_q < CNT_W'(DEPTH)) || (ow_ia_valid && iw_ready));
    assign push     = ow_mem_req && iw_mem_gnt;

    // Next-state for PC, pointers, count and the registered queue head
    always_comb begin
        pc_n         = pc_q;
        wr_ptr_n     = wr_ptr_q;
        rd_ptr_n     = rd_ptr_q;
        count_n      = count_q;
        head_valid_n = 1'b0;
        head_pc_n    = '0;
        if (iw_flush) begin
            pc_n     = iw_flush_pc;
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
        end else begin
            if (push) begin
                pc_n     = pc_q + ADDR_W'(FETCH_W);
                wr_ptr_n = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_n = rd_ptr_q + PTR_W'(1);
            end
            count_n = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        head_valid_n = (count_n != '0);
        // Entry being written this cycle is forwarded when it becomes the head
        if (head_valid_n) begin
            if (push && (rd_ptr_n == wr_ptr_q)) begin
                head_pc_n = pc_q;
            end else begin
                head_pc_n = mem_q[rd_ptr_n];
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            pc_q        <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ow_pc       <= '0;
            ow_ia_valid <= 1'b0;
        end else begin
            pc_q        <= pc_n;
            wr_ptr_q    <= wr_ptr_n;
            rd_ptr_q    <= rd_ptr_n;
            count_q     <= count_n;
            ow_pc       <= head_pc_n;
            ow_ia_valid <= head_valid_n;
        end
    end

    // Queue storage; contents are only meaningful between pointers
    always_ff @(posedge iw_clk) begin
        if (push && !iw_flush) begin
            mem_q[wr_ptr_q] <= pc_q;
        end
    end

`ifdef STG1IA_PQ_PERF_EN
    logic stall;
    assign stall = (ow_mem_req && !iw_mem_gnt) ||
                   ((count_q == CNT_W'(DEPTH)) && !(ow_ia_valid && iw_ready));

    // Saturating performance counters
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            ow_perf_stall <= '0;
            ow_perf_flush <= '0;
        end else begin
            if (stall && (ow_perf_stall != '1)) begin
                ow_perf_stall <= ow_perf_stall + 32'd1;
            end
            if (iw_flush && (ow_perf_flush != '1)) begin
                ow_perf_flush <= ow_perf_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stg1ia_pq.sv
// Directed self-checking bench for stg1ia_pq (ADDR_W=24, FETCH_W=2, DEPTH=4).
module tb_stg1ia_pq;

    logic        iw_clk;
    logic        iw_rst_n;
    logic [47:0] ow_mem_addr;
    logic        ow_mem_req;
    logic        iw_mem_gnt;
    logic [23:0] ow_pc;
    logic        ow_ia_valid;
    logic        iw_ready;
    logic [2:0]  ow_count;
    logic        iw_flush;
    logic [23:0] iw_flush_pc;
`ifdef STG1IA_PQ_PERF_EN
    logic [31:0] ow_perf_stall;
    logic [31:0] ow_perf_flush;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    stg1ia_pq #(.ADDR_W(24), .FETCH_W(2), .DEPTH(4), .RESET_PC(24'h0)) dut (
        .iw_clk      (iw_clk),
        .iw_rst_n    (iw_rst_n),
        .ow_mem_addr (ow_mem_addr),
        .ow_mem_req  (ow_mem_req),
        .iw_mem_gnt  (iw_mem_gnt),
        .ow_pc       (ow_pc),
        .ow_ia_valid (ow_ia_valid),
        .iw_ready    (iw_ready),
        .ow_count    (ow_count),
        .iw_flush    (iw_flush),
        .iw_flush_pc (iw_flush_pc)
`ifdef STG1IA_PQ_PERF_EN
        ,
        .ow_perf_stall (ow_perf_stall),
        .ow_perf_flush (ow_perf_flush)
`endif
    );

    initial iw_clk = 1'b0;
    always #5 iw_clk = ~iw_clk;

    task automatic step();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic do_reset();
        iw_rst_n    = 1'b0;
        iw_flush    = 1'b0;
        iw_flush_pc = '0;
        iw_mem_gnt  = 1'b0;
        iw_ready    = 1'b0;
        step();
        iw_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [23:0] exp_pc;
        iw_rst_n = 1'b0; iw_flush = 1'b0; iw_flush_pc = '0;
        iw_mem_gnt = 1'b1; iw_ready = 1'b1;
        #1;
        n_checks++; if (ow_mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", ow_mem_req); end
        n_checks++; if (ow_ia_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", ow_ia_valid); end
        n_checks++; if (ow_pc !== 24'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", ow_pc); end
        n_checks++; if (ow_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", ow_count); end
        step(); step();
        iw_rst_n = 1'b1;
        #1;
        n_checks++; if (ow_mem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b exp 1", ow_mem_req); end
        n_checks++; if (ow_mem_addr !== {24'h000001, 24'h000000}) begin n_fail++; $display("FAIL first_addr: got %h exp 000001000000", ow_mem_addr); end
        step();
        n_checks++; if (ow_count !== 3'd1) begin n_fail++; $display("FAIL first_count: got %0d exp 1", ow_count); end
        exp_pc = 24'h0;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (ow_ia_valid !== 1'b1 || ow_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc%0d: got v=%b pc=%h exp v=1 pc=%h", k, ow_ia_valid, ow_pc, exp_pc); end
            exp_pc = exp_pc + 24'd2;
            step();
        end
    endtask

    task automatic test_full();
        do_reset();
        iw_ready = 1'b0; iw_mem_gnt = 1'b1;
        repeat (4) step();
        n_checks++; if (ow_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d exp 4", ow_count); end
        n_checks++; if (ow_mem_req !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b exp 0", ow_mem_req); end
        n_checks++; if (ow_pc !== 24'h0) begin n_fail++; $display("FAIL full_head: got %h exp 0", ow_pc); end
        step();
        n_checks++; if (ow_count !== 3'd4) begin n_fail++; $display("FAIL full_hold: got %0d exp 4", ow_count); end
        iw_ready = 1'b1;
        #1;
        n_checks++; if (ow_mem_req !== 1'b1) begin n_fail++; $display("FAIL full_pop_req: got %b exp 1", ow_mem_req); end
        step();
        n_checks++; if (ow_count !== 3'd4) begin n_fail++; $display("FAIL pushpop_count: got %0d exp 4", ow_count); end
        n_checks++; if (ow_pc !== 24'h2) begin n_fail++; $display("FAIL pushpop_head: got %h exp 2", ow_pc); end
        iw_ready = 1'b0;
        #1;
        n_checks++; if (ow_mem_req !== 1'b0) begin n_fail++; $display("FAIL refull_req: got %b exp 0", ow_mem_req); end
    endtask

    task automatic test_stall();
        do_reset();
        iw_flush = 1'b1; iw_flush_pc = 24'h10; iw_mem_gnt = 1'b0; iw_ready = 1'b1;
        step();
        iw_flush = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (ow_mem_addr !== {24'h000011, 24'h000010} || ow_mem_req !== 1'b1) begin n_fail++; $display("FAIL stall_addr%0d: got addr=%h req=%b exp 000011000010 req=1", k, ow_mem_addr, ow_mem_req); end
            step();
        end
        n_checks++; if (ow_count !== 3'd0) begin n_fail++; $display("FAIL stall_count: got %0d exp 0", ow_count); end
        iw_mem_gnt = 1'b1;
        step();
        iw_mem_gnt = 1'b0;
        #1;
        n_checks++; if (ow_mem_addr !== {24'h000013, 24'h000012}) begin n_fail++; $display("FAIL grant_addr: got %h exp 000013000012", ow_mem_addr); end
        n_checks++; if (ow_ia_valid !== 1'b1 || ow_pc !== 24'h10) begin n_fail++; $display("FAIL grant_head: got v=%b pc=%h exp v=1 pc=10", ow_ia_valid, ow_pc); end
    endtask

    task automatic test_flush();
        do_reset();
        iw_ready = 1'b0; iw_mem_gnt = 1'b1;
        repeat (3) step();
        n_checks++; if (ow_count !== 3'd3) begin n_fail++; $display("FAIL preflush_count: got %0d exp 3", ow_count); end
        iw_flush = 1'b1; iw_flush_pc = 24'h400; iw_ready = 1'b1;
        #1;
        n_checks++; if (ow_mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req: got %b exp 0", ow_mem_req); end
        step();
        iw_flush = 1'b0;
        #1;
        n_checks++; if (ow_count !== 3'd0 || ow_ia_valid !== 1'b0 || ow_pc !== 24'h0) begin n_fail++; $display("FAIL flush_clear: got cnt=%0d v=%b pc=%h exp 0 0 0", ow_count, ow_ia_valid, ow_pc); end
        n_checks++; if (ow_mem_addr !== {24'h000401, 24'h000400} || ow_mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_addr: got %h req=%b exp 000401000400 req=1", ow_mem_addr, ow_mem_req); end
        step();
        n_checks++; if (ow_count !== 3'd1 || ow_pc !== 24'h400) begin n_fail++; $display("FAIL flush_first: got cnt=%0d pc=%h exp 1 400", ow_count, ow_pc); end
        iw_flush = 1'b1; iw_flush_pc = 24'h100;
        step();
        iw_flush_pc = 24'h200;
        step();
        iw_flush = 1'b0;
        #1;
        n_checks++; if (ow_mem_addr !== {24'h000201, 24'h000200} || ow_count !== 3'd0) begin n_fail++; $display("FAIL flush_last_wins: got %h cnt=%0d exp 000201000200 cnt=0", ow_mem_addr, ow_count); end
    endtask

    task automatic test_wrap();
        iw_flush = 1'b1; iw_flush_pc = 24'hFFFFFF; iw_mem_gnt = 1'b0; iw_ready = 1'b1;
        step();
        iw_flush = 1'b0;
        #1;
        n_checks++; if (ow_mem_addr !== {24'h000000, 24'hFFFFFF}) begin n_fail++; $display("FAIL wrap_addr: got %h exp 000000ffffff", ow_mem_addr); end
        iw_mem_gnt = 1'b1;
        step();
        iw_mem_gnt = 1'b0;
        #1;
        n_checks++; if (ow_mem_addr !== {24'h000002, 24'h000001}) begin n_fail++; $display("FAIL wrap_pc: got %h exp 000002000001", ow_mem_addr); end
        n_checks++; if (ow_pc !== 24'hFFFFFF || ow_ia_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_head: got pc=%h v=%b exp ffffff 1", ow_pc, ow_ia_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        iw_mem_gnt = 1'b1; iw_ready = 1'b0;
        step(); step();
        n_checks++; if (ow_count !== 3'd2) begin n_fail++; $display("FAIL pre_async_count: got %0d exp 2", ow_count); end
        #2;
        iw_rst_n = 1'b0;
        #1;
        n_checks++; if (ow_ia_valid !== 1'b0 || ow_pc !== 24'h0 || ow_count !== 3'd0) begin n_fail++; $display("FAIL async_state: got v=%b pc=%h cnt=%0d exp 0 0 0", ow_ia_valid, ow_pc, ow_count); end
        n_checks++; if (ow_mem_req !== 1'b0 || ow_mem_addr !== {24'h000001, 24'h000000}) begin n_fail++; $display("FAIL async_req: got req=%b addr=%h exp 0 000001000000", ow_mem_req, ow_mem_addr); end
`ifdef STG1IA_PQ_PERF_EN
        n_checks++; if (ow_perf_stall !== 32'd0 || ow_perf_flush !== 32'd0) begin n_fail++; $display("FAIL perf_reset: got %0d %0d exp 0 0", ow_perf_stall, ow_perf_flush); end
`endif
        step();
        iw_rst_n = 1'b1; iw_mem_gnt = 1'b0;
        repeat (5) step();
        n_checks++; if (ow_count !== 3'd0 || ow_mem_addr !== {24'h000001, 24'h000000}) begin n_fail++; $display("FAIL nogrant_hold: got cnt=%0d addr=%h exp 0 000001000000", ow_count, ow_mem_addr); end
`ifdef STG1IA_PQ_PERF_EN
        n_checks++; if (ow_perf_stall !== 32'd5) begin n_fail++; $display("FAIL perf_stall: got %0d exp 5", ow_perf_stall); end
        iw_flush = 1'b1; iw_flush_pc = 24'h0;
        step();
        iw_flush = 1'b0;
        n_checks++; if (ow_perf_flush !== 32'd1) begin n_fail++; $display("FAIL perf_flush: got %0d exp 1", ow_perf_flush); end
`endif
    endtask

    initial begin
        test_reset();
        test_full();
        test_stall();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
